// File: rtl/stage_queue_pkg.sv
// Shared fetch-side parameters and the default pointer/count types for stage_queue.
package stage_queue_pkg;

    localparam int unsigned FETCH_WIDTH = 2;
    localparam int unsigned SQ_LANES    = FETCH_WIDTH;
    localparam int unsigned SQ_DEPTH    = 8;
    localparam int unsigned SQ_DATA_W   = 64;
    localparam int unsigned SQ_PTR_W    = $clog2(SQ_DEPTH);
    localparam int unsigned SQ_CNT_W    = $clog2(SQ_DEPTH + 1);

    typedef logic [SQ_PTR_W-1:0] sq_ptr_t;
    typedef logic [SQ_CNT_W-1:0] sq_count_t;

endpackage

// File: rtl/lane_compact.sv
// Per-lane exclusive prefix count of a mask plus its total popcount.
module lane_compact #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                        i_mask,
    output logic [N-1:0][$clog2(N + 1)-1:0]     o_offset,
    output logic [$clog2(N + 1)-1:0]            o_popcount
);

    localparam int unsigned CW = $clog2(N + 1);

    always_comb begin
        logic [CW-1:0] w_acc;
        w_acc = '0;
        for (int i = 0; i < N; i++) begin
            o_offset[i] = w_acc;
            w_acc       = w_acc + CW'(i_mask[i]);
        end
        o_popcount = w_acc;
    end

endmodule

// File: rtl/stage_queue.sv
// Multi-lane circular staging queue: compacted group enqueue, in-order multi-lane dequeue.
module stage_queue
    import stage_queue_pkg::*;
#(
    parameter int unsigned LANES  = SQ_LANES,
    parameter int unsigned DEPTH  = SQ_DEPTH,
    parameter int unsigned DATA_W = SQ_DATA_W
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_flush,
    input  logic [LANES-1:0]                   i_in_valid,
    input  logic [LANES-1:0][DATA_W-1:0]       i_in_data,
    output logic                               o_in_ready,
    output logic [LANES-1:0]                   o_out_valid,
    output logic [LANES-1:0][DATA_W-1:0]       o_out_data,
    input  logic [LANES-1:0]                   i_out_ready,
    output logic [$clog2(DEPTH + 1)-1:0]       o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LW    = $clog2(LANES + 1);

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic                      w_enq_fire;
    logic [LANES-1:0]          w_enq_mask;
    logic [LANES-1:0][LW-1:0]  w_enq_off;
    logic [LW-1:0]             w_enq_cnt;
    logic [LANES-1:0]          w_deq_mask;
    logic [LANES-1:0]          w_deq_lead;
    logic [LANES-1:0][LW-1:0]  w_lead_off_unused;
    logic [LW-1:0]             w_deq_k;

    // Readiness looks only at the registered count so it never depends on out_ready.
    assign o_in_ready = (r_count <= CNT_W'(DEPTH - LANES));
    assign w_enq_fire = o_in_ready & ~i_flush & ~i_reset;
    assign w_enq_mask = i_in_valid & {LANES{w_enq_fire}};
    assign o_count    = r_count;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            o_out_valid[i] = (r_count > CNT_W'(i));
            o_out_data[i]  = r_mem[r_head + PTR_W'(i)];
        end
    end

    // Only the unbroken run of accepted lanes starting at lane 0 is consumed.
    always_comb begin
        logic w_run;
        w_run      = 1'b1;
        w_deq_mask = o_out_valid & i_out_ready;
        for (int i = 0; i < LANES; i++) begin
            w_run         = w_run & w_deq_mask[i];
            w_deq_lead[i] = w_run;
        end
    end

    lane_compact #(
        .N          (LANES)
    ) u_enq_compact (
        .i_mask     (w_enq_mask),
        .o_offset   (w_enq_off),
        .o_popcount (w_enq_cnt)
    );

    lane_compact #(
        .N          (LANES)
    ) u_deq_compact (
        .i_mask     (w_deq_lead),
        .o_offset   (w_lead_off_unused),
        .o_popcount (w_deq_k)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_k);
            r_tail  <= r_tail + PTR_W'(w_enq_cnt);
            r_count <= r_count + CNT_W'(w_enq_cnt) - CNT_W'(w_deq_k);
        end
    end

    // Storage is never reset; pointers and count alone define what is live.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (w_enq_mask[l]) begin
                r_mem[r_tail + PTR_W'(w_enq_off[l])] <= i_in_data[l];
            end
        end
    end

endmodule

// File: tb/tb_stage_queue.sv
// Directed plus random bench for stage_queue against a queue-based reference model.
module tb_stage_queue;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 64;

    logic                          i_clk;
    logic                          i_reset;
    logic                          i_flush;
    logic [LANES-1:0]              i_in_valid;
    logic [LANES-1:0][DATA_W-1:0]  i_in_data;
    logic                          o_in_ready;
    logic [LANES-1:0]              o_out_valid;
    logic [LANES-1:0][DATA_W-1:0]  o_out_data;
    logic [LANES-1:0]              i_out_ready;
    logic [$clog2(DEPTH + 1)-1:0]  o_count;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model_q [$];

    stage_queue #(
        .LANES       (LANES),
        .DEPTH       (DEPTH),
        .DATA_W      (DATA_W)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .i_out_ready (i_out_ready),
        .o_count     (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [LANES-1:0] exp_valid;
        n = model_q.size();
        for (int i = 0; i < LANES; i++) exp_valid[i] = (n > i);
        chk({tag, " count"}, 64'(o_count), 64'(n));
        chk({tag, " in_ready"}, 64'(o_in_ready), 64'((DEPTH - n) >= LANES));
        chk({tag, " out_valid"}, 64'(o_out_valid), 64'(exp_valid));
        for (int i = 0; i < LANES; i++) begin
            if (i < n) chk($sformatf("%s data%0d", tag, i), o_out_data[i], model_q[i]);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then sample after the edge.
    task automatic step(input logic rst, input logic fl, input logic [1:0] iv,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [1:0] ordy, input string tag);
        int n;
        int k;
        bit rdy;
        i_reset        = rst;
        i_flush        = fl;
        i_in_valid     = iv;
        i_in_data[0]   = d0;
        i_in_data[1]   = d1;
        i_out_ready    = ordy;
        if (rst || fl) begin
            model_q.delete();
        end else begin
            n   = model_q.size();
            rdy = ((DEPTH - n) >= LANES);
            k   = 0;
            while (k < LANES && k < n && ordy[k]) k++;
            repeat (k) void'(model_q.pop_front());
            if (rdy) begin
                if (iv[0]) model_q.push_back(d0);
                if (iv[1]) model_q.push_back(d1);
            end
        end
        @(posedge i_clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_flush     = 1'b0;
        i_in_valid  = '0;
        i_in_data   = '0;
        i_out_ready = '0;

        step(1, 0, 2'b11, 64'h1, 64'h2, 2'b11, "reset");
        step(1, 0, 2'b00, 64'h0, 64'h0, 2'b00, "reset2");

        // Basic two-lane enqueue and single upper-lane enqueue.
        step(0, 0, 2'b11, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 2'b00, "pairAB");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b11, "drain1");
        step(0, 0, 2'b10, 64'hDEAD, 64'hCCCC_0000_0000_000C, 2'b00, "lane1C");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b01, "drain2");

        // Fill to 7, stall, then dequeue two.
        step(0, 0, 2'b11, 64'h10, 64'h11, 2'b00, "fill1");
        step(0, 0, 2'b11, 64'h12, 64'h13, 2'b00, "fill2");
        step(0, 0, 2'b11, 64'h14, 64'h15, 2'b00, "fill3");
        step(0, 0, 2'b01, 64'h16, 64'h99, 2'b00, "fill4");
        step(0, 0, 2'b11, 64'hBAD0, 64'hBAD1, 2'b00, "full_stall");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b11, "deq_two");

        // Leading-run dequeue and simultaneous enqueue/dequeue.
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b01, "deq_one");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b10, "gap_ready");
        step(0, 0, 2'b11, 64'h20, 64'h21, 2'b01, "enq_deq");

        // Move head/tail to slot 7, then enqueue a group across the wrap.
        step(1, 0, 2'b00, 64'h0, 64'h0, 2'b00, "reset3");
        step(0, 0, 2'b11, 64'h30, 64'h31, 2'b00, "w_fill1");
        step(0, 0, 2'b11, 64'h32, 64'h33, 2'b00, "w_fill2");
        step(0, 0, 2'b11, 64'h34, 64'h35, 2'b00, "w_fill3");
        step(0, 0, 2'b01, 64'h36, 64'h0, 2'b00, "w_fill4");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b11, "w_deq1");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b11, "w_deq2");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b11, "w_deq3");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b01, "w_deq4");
        step(0, 0, 2'b11, 64'hDDDD_0000_0000_000D, 64'hEEEE_0000_0000_000E, 2'b00, "wrapDE");
        step(0, 0, 2'b01, 64'hFFFF_0000_0000_000F, 64'h0, 2'b00, "after_wrap");

        // Flush beats a concurrent enqueue and dequeue.
        step(0, 0, 2'b11, 64'h40, 64'h41, 2'b00, "pre_fl1");
        step(0, 0, 2'b01, 64'h42, 64'h0, 2'b00, "pre_fl2");
        step(0, 1, 2'b11, 64'h50, 64'h51, 2'b11, "flush");
        step(0, 0, 2'b00, 64'h0, 64'h0, 2'b11, "post_flush");

        for (int i = 0; i < 400; i++) begin
            logic rr;
            logic ff;
            rr = ($urandom_range(0, 63) == 0);
            ff = ($urandom_range(0, 31) == 0);
            step(rr, ff, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                 2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_queue.md
STAGE_QUEUE -- requirements
Module: stage_queue

Interface
REQ-001 Parameter LANES, default 2 (FETCH_WIDTH); lanes per enqueue/dequeue group.
REQ-002 Parameter DEPTH, default 8; entry count; power of two and >= 2*LANES.
REQ-003 Parameter DATA_W, default 64; payload bits per entry.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 flush  input  1  discard all stored and incoming entries.
REQ-007 in_valid  input  LANES  per-lane enqueue valid; any mask pattern allowed.
REQ-008 in_data  input  LANES x DATA_W  per-lane payload.
REQ-009 in_ready  output  1  whole group accepted this cycle.
REQ-010 out_valid  output  LANES  lane i holds the (i+1)-th oldest entry.
REQ-011 out_data  output  LANES x DATA_W  lane i = entry at head+i.
REQ-012 out_ready  input  LANES  consumer accept mask.
REQ-013 count  output  clog2(DEPTH+1)  stored-entry count.

Function
REQ-014 in_ready SHALL be 1 iff (DEPTH - count) >= LANES, using registered count only; no dependence on same-cycle dequeue.
REQ-015 On in_ready & !flush, the valid lanes SHALL be compacted in ascending lane order and written at tail, tail+1, ...; invalid lanes consume no slot.
REQ-016 out_valid[i] SHALL equal (count > i); out_data of invalid lanes is don't-care.
REQ-017 Dequeue number k SHALL be the length of the leading run of ones in (out_valid & out_ready); lanes after the first zero are not consumed even if ready.
REQ-018 head advances by k, tail by the enqueued popcount, count updates by enq - k, all in the same cycle; simultaneous enqueue and dequeue are both honoured.
REQ-019 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; a group spanning the wrap point is stored contiguously modulo DEPTH.
REQ-020 No combinational input-to-output path: minimum latency one cycle from enqueue to out_valid.
REQ-021 Empty (count=0): out_valid all 0; dequeue ignored.
REQ-022 Full (count=DEPTH): in_ready 0; in_data ignored; stored entries unchanged.
REQ-023 flush SHALL take priority over enqueue and dequeue: next cycle head=tail=0, count=0; same-cycle input group discarded.
REQ-024 Enqueue with in_ready=0 SHALL have no effect; producer holds data (stall semantics).

Reset
REQ-025 On reset=1 at a clock edge: head=0, tail=0, count=0; out_valid=0, in_ready=1 next cycle.
REQ-026 reset SHALL override flush and any in-flight enqueue/dequeue; storage array need not be cleared.

Structure
REQ-027 LANES/DEPTH defaults and the entry-pointer and count typedefs SHALL live in the shared common package next to FETCH_WIDTH.
REQ-028 Lane compaction (valid mask -> per-lane slot offset and popcount) SHALL be a sub-module named lane_compact, reused for leading-run dequeue count.
REQ-029 Storage SHALL be a flop array indexed by pointer; no RAM macro.

Verification
REQ-030 Reset, then in_valid=2'b11, data {A,B} -> next cycle count=2, out_valid=2'b11, out_data={A,B} (lane0=A).
REQ-031 in_valid=2'b10, data lane1=C into empty queue -> count=1, out_data[0]=C, out_valid=2'b01.
REQ-032 Fill to count=7 (DEPTH=8) -> in_ready=0; enqueue attempt leaves count=7; out_ready=2'b11 -> count=5, in_ready=1 next cycle.
REQ-033 count=4, out_ready=2'b10 -> nothing dequeued, count=4; out_ready=2'b01 with simultaneous 2-lane enqueue -> count=5.
REQ-034 head=7, tail=7 (count=0), enqueue {D,E} -> D in slot 7, E in slot 0; out_data={D,E}; tail=1.
REQ-035 count=6, flush=1 with in_valid=2'b11 and out_ready=2'b11 -> next cycle count=0, out_valid=0, in_ready=1; the input group never appears at output.
